// File: rtl/control_unit_if.sv
// Memory handshake between the controller and external memory: request strobes
// travel out from the controller, mem_ready comes back when the access completes.
interface control_unit_if;
  logic mem_rd;
  logic mem_wr;
  logic mem_ready;

  modport master (
    output mem_rd,
    output mem_wr,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    output mem_ready
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired multi-cycle controller for the 16-bit datapath: fetch/decode/execute
// sequencing and memory handshake. Define CU_MEM_TIMEOUT_EN for the wait-cycle watchdog.
module control_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  control_unit_if.master        mem,
  input  logic [15:0]           ir,
  input  logic                  zin,
  input  logic                  sin,
  input  logic                  vin,
  input  logic                  cin,
  output logic                  lmar,
  output logic                  lpc,
  output logic                  lir,
  output logic                  lmdr,
  output logic                  ldx,
  output logic                  ldy,
  output logic                  tpc,
  output logic                  tp,
  output logic                  t2,
  output logic                  tmdr2x,
  output logic                  rmarx,
  output logic                  rmdri,
  output logic                  rdr,
  output logic                  wrr,
  output logic [2:0]            pa,
  output logic [2:0]            wpa,
  output logic [2:0]            fnsel,
  output logic [3:0]            flags,
  output logic                  halted,
  output logic                  illegal
`ifdef CU_MEM_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  typedef enum logic [4:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_EX0, S_EX1, S_EX2,
    S_L0, S_L1, S_L2, S_L3, S_L4,
    S_S0, S_S1, S_S2, S_S3, S_S4,
    S_B0, S_B1, S_HALT
  } state_e;

  typedef struct packed {
    logic       lmar;
    logic       lpc;
    logic       lir;
    logic       lmdr;
    logic       ldx;
    logic       ldy;
    logic       tpc;
    logic       tp;
    logic       t2;
    logic       tmdr2x;
    logic       rmarx;
    logic       rmdri;
    logic       rdr;
    logic       wrr;
    logic [2:0] pa;
    logic [2:0] wpa;
    logic [2:0] fnsel;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
    logic       halted;
  } ctl_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h4;
  localparam logic [3:0] OP_ST  = 4'h5;
  localparam logic [3:0] OP_BRZ = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] FN_ADD = 3'b100;

  if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
    $error("control_unit: TIMEOUT must lie in 1..31 to fit the 5-bit wait counter");
  end

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  ctl_t       ctl_c;
  ctl_t       ctl_o;

  logic [3:0] op;
  logic [2:0] rd, rs, rt;
  logic       unused_ir_lsb;

  assign op = ir[15:12];
  assign rd = ir[11:9];
  assign rs = ir[8:6];
  assign rt = ir[5:3];
  assign unused_ir_lsb = ^ir[2:0];

  logic wait_expired;

`ifdef CU_MEM_TIMEOUT_EN
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

  logic [4:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       in_wait;

  // The counter sits at zero outside the wait states, so it is clear on every entry.
  assign in_wait      = (state_q == S_FETCH3) || (state_q == S_L2) || (state_q == S_S4);
  assign cnt_d        = in_wait ? cnt_q + 5'd1 : 5'd0;
  assign wait_expired = in_wait && !mem.mem_ready && (cnt_q == TO_LAST);
  assign timeout_d    = timeout_q | wait_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    ctl_c   = '0;

    unique case (state_q)
      S_FETCH0: begin
        ctl_c.tpc = 1'b1;
        ctl_c.ldy = 1'b1;
        state_d   = S_FETCH1;
      end
      S_FETCH1: begin
        ctl_c.lmar = 1'b1;
        ctl_c.t2   = 1'b1;
        ctl_c.ldx  = 1'b1;
        state_d    = S_FETCH2;
      end
      S_FETCH2: begin
        ctl_c.fnsel  = FN_ADD;
        ctl_c.lpc    = 1'b1;
        ctl_c.mem_rd = 1'b1;
        state_d      = S_FETCH3;
      end
      S_FETCH3: begin
        ctl_c.mem_rd = 1'b1;
        ctl_c.lir    = mem.mem_ready;
        if (mem.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EX0;
          OP_LD:  state_d = S_L0;
          OP_ST:  state_d = S_S0;
          OP_BRZ: state_d = flags_q[0] ? S_B0 : S_FETCH0;
          OP_JMP: state_d = S_B0;
          OP_HLT: state_d = S_HALT;
          default: begin
            ctl_c.illegal = 1'b1;
            state_d       = S_FETCH0;
          end
        endcase
      end
      S_EX0: begin
        ctl_c.pa  = rs;
        ctl_c.rdr = 1'b1;
        ctl_c.tp  = 1'b1;
        ctl_c.ldx = 1'b1;
        state_d   = S_EX1;
      end
      S_EX1: begin
        ctl_c.pa  = rt;
        ctl_c.rdr = 1'b1;
        ctl_c.tp  = 1'b1;
        ctl_c.ldy = 1'b1;
        state_d   = S_EX2;
      end
      S_EX2: begin
        // Opcodes 0000..0011 map straight onto ALU functions 100..111.
        ctl_c.fnsel = {1'b1, op[1:0]};
        ctl_c.wrr   = 1'b1;
        ctl_c.wpa   = rd;
        flags_d     = {cin, sin, vin, zin};
        state_d     = S_FETCH0;
      end
      S_L0, S_S0, S_B0: begin
        ctl_c.pa  = rs;
        ctl_c.rdr = 1'b1;
        ctl_c.tp  = 1'b1;
        ctl_c.ldy = 1'b1;
        if (state_q == S_L0)      state_d = S_L1;
        else if (state_q == S_S0) state_d = S_S1;
        else                      state_d = S_B1;
      end
      S_L1: begin
        ctl_c.lmar = 1'b1;
        state_d    = S_L2;
      end
      S_L2: begin
        ctl_c.mem_rd = 1'b1;
        ctl_c.rmarx  = mem.mem_ready;
        ctl_c.lmdr   = mem.mem_ready;
        if (mem.mem_ready) state_d = S_L3;
      end
      S_L3: begin
        ctl_c.tmdr2x = 1'b1;
        ctl_c.ldy    = 1'b1;
        state_d      = S_L4;
      end
      S_L4: begin
        ctl_c.wrr = 1'b1;
        ctl_c.wpa = rd;
        state_d   = S_FETCH0;
      end
      S_S1: begin
        ctl_c.lmar = 1'b1;
        state_d    = S_S2;
      end
      S_S2: begin
        ctl_c.pa  = rt;
        ctl_c.rdr = 1'b1;
        ctl_c.tp  = 1'b1;
        ctl_c.ldy = 1'b1;
        state_d   = S_S3;
      end
      S_S3: begin
        ctl_c.rmdri = 1'b1;
        ctl_c.lmdr  = 1'b1;
        state_d     = S_S4;
      end
      S_S4: begin
        ctl_c.mem_wr = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH0;
      end
      S_B1: begin
        ctl_c.lpc = 1'b1;
        state_d   = S_FETCH0;
      end
      S_HALT: begin
        ctl_c.halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH0;
      end
    endcase

    if (wait_expired) state_d = S_HALT;
  end

  // Reset also masks the decodes so memory requests drop without waiting for a clock.
  assign ctl_o = rst ? ctl_c : '0;

  assign lmar       = ctl_o.lmar;
  assign lpc        = ctl_o.lpc;
  assign lir        = ctl_o.lir;
  assign lmdr       = ctl_o.lmdr;
  assign ldx        = ctl_o.ldx;
  assign ldy        = ctl_o.ldy;
  assign tpc        = ctl_o.tpc;
  assign tp         = ctl_o.tp;
  assign t2         = ctl_o.t2;
  assign tmdr2x     = ctl_o.tmdr2x;
  assign rmarx      = ctl_o.rmarx;
  assign rmdri      = ctl_o.rmdri;
  assign rdr        = ctl_o.rdr;
  assign wrr        = ctl_o.wrr;
  assign pa         = ctl_o.pa;
  assign wpa        = ctl_o.wpa;
  assign fnsel      = ctl_o.fnsel;
  assign illegal    = ctl_o.illegal;
  assign halted     = ctl_o.halted;
  assign mem.mem_rd = ctl_o.mem_rd;
  assign mem.mem_wr = ctl_o.mem_wr;
  assign flags      = flags_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle and
// compares the full control word against hand-computed values.
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] ir;
  logic        zin, sin, vin, cin;
  logic        lmar, lpc, lir, lmdr, ldx, ldy;
  logic        tpc, tp, t2, tmdr2x;
  logic        rmarx, rmdri, rdr, wrr;
  logic [2:0]  pa, wpa, fnsel;
  logic [3:0]  flags;
  logic        halted, illegal;
`ifdef CU_MEM_TIMEOUT_EN
  logic        timeout;
`endif

  control_unit_if mem_if ();

  control_unit #(.TIMEOUT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem     (mem_if),
    .ir      (ir),
    .zin     (zin),
    .sin     (sin),
    .vin     (vin),
    .cin     (cin),
    .lmar    (lmar),
    .lpc     (lpc),
    .lir     (lir),
    .lmdr    (lmdr),
    .ldx     (ldx),
    .ldy     (ldy),
    .tpc     (tpc),
    .tp      (tp),
    .t2      (t2),
    .tmdr2x  (tmdr2x),
    .rmarx   (rmarx),
    .rmdri   (rmdri),
    .rdr     (rdr),
    .wrr     (wrr),
    .pa      (pa),
    .wpa     (wpa),
    .fnsel   (fnsel),
    .flags   (flags),
    .halted  (halted),
    .illegal (illegal)
`ifdef CU_MEM_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  // Observed control word: 18 strobes, then pa, wpa, fnsel.
  logic [26:0] obs;
  assign obs = {lmar, lpc, lir, lmdr, ldx, ldy, tpc, tp, t2, tmdr2x, rmarx, rmdri,
                rdr, wrr, mem_if.mem_rd, mem_if.mem_wr, illegal, halted, pa, wpa, fnsel};

  localparam logic [26:0] LMAR    = 27'd1 << 26;
  localparam logic [26:0] LPC     = 27'd1 << 25;
  localparam logic [26:0] LIR     = 27'd1 << 24;
  localparam logic [26:0] LMDR    = 27'd1 << 23;
  localparam logic [26:0] LDX     = 27'd1 << 22;
  localparam logic [26:0] LDY     = 27'd1 << 21;
  localparam logic [26:0] TPC     = 27'd1 << 20;
  localparam logic [26:0] TP      = 27'd1 << 19;
  localparam logic [26:0] T2      = 27'd1 << 18;
  localparam logic [26:0] TMDR2X  = 27'd1 << 17;
  localparam logic [26:0] RMARX   = 27'd1 << 16;
  localparam logic [26:0] RMDRI   = 27'd1 << 15;
  localparam logic [26:0] RDR     = 27'd1 << 14;
  localparam logic [26:0] WRR     = 27'd1 << 13;
  localparam logic [26:0] MRD     = 27'd1 << 12;
  localparam logic [26:0] MWR     = 27'd1 << 11;
  localparam logic [26:0] ILLEGAL = 27'd1 << 10;
  localparam logic [26:0] HALTED  = 27'd1 << 9;
  localparam logic [26:0] NONE    = 27'd0;

  function automatic logic [26:0] PA(input logic [2:0] r);
    return {18'd0, r, 6'd0};
  endfunction
  function automatic logic [26:0] WPA(input logic [2:0] r);
    return {21'd0, r, 3'd0};
  endfunction
  function automatic logic [26:0] FN(input logic [2:0] f);
    return {24'd0, f};
  endfunction

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  // Called at posedge+1: settle, compare the control word, advance one cycle.
  task automatic step(input string tag, input logic [26:0] e);
    #2;
    check(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] f);
    {cin, sin, vin, zin} = f;
  endtask

  task automatic fetch(input logic [15:0] instr);
    ir = instr;
    mem_if.mem_ready = 1'b0;
    step("fetch0", TPC | LDY);
    step("fetch1", LMAR | T2 | LDX);
    mem_if.mem_ready = 1'b1;
    step("fetch2", LPC | MRD | FN(3'b100));
    step("fetch3", MRD | LIR);
    mem_if.mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ir  = 16'h0000;
    set_alu(4'b1111);
    mem_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_ctl", 32'(obs), 32'(NONE));
    check("reset_flags", 32'(flags), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ADD R1,R1,R2
    fetch(16'h0250);
    step("add_decode", NONE);
    step("add_ex0", PA(3'd1) | RDR | TP | LDX);
    step("add_ex1", PA(3'd2) | RDR | TP | LDY);
    set_alu(4'b0000);
    step("add_ex2", WRR | WPA(3'd1) | FN(3'b100));
    check("add_flags", 32'(flags), 32'h0);

    // BRZ R4 with z clear: straight back to fetch
    set_alu(4'b1111);
    fetch(16'h6100);
    step("brz_nt_decode", NONE);
    check("brz_nt_flags", 32'(flags), 32'h0);

    // SUB R3,R1,R1
    set_alu(4'b1110);
    fetch(16'h1648);
    step("sub_decode", NONE);
    step("sub_ex0", PA(3'd1) | RDR | TP | LDX);
    step("sub_ex1", PA(3'd1) | RDR | TP | LDY);
    set_alu(4'b0001);
    step("sub_ex2", WRR | WPA(3'd3) | FN(3'b101));
    set_alu(4'b1110);
    check("sub_flags", 32'(flags), 32'h1);

    // BRZ R4 with z set
    fetch(16'h6100);
    step("brz_t_decode", NONE);
    step("brz_t_b0", PA(3'd4) | RDR | TP | LDY);
    step("brz_t_b1", LPC);

    // LD R5,[R2] with three wait cycles
    fetch(16'h4A80);
    step("ld_decode", NONE);
    step("ld_l0", PA(3'd2) | RDR | TP | LDY);
    step("ld_l1", LMAR);
    for (int i = 0; i < 3; i++) step("ld_wait", MRD);
    mem_if.mem_ready = 1'b1;
    step("ld_ready", MRD | RMARX | LMDR);
    mem_if.mem_ready = 1'b0;
    step("ld_l3", TMDR2X | LDY);
    step("ld_l4", WRR | WPA(3'd5));

    // ST [R2],R6 with one wait cycle
    fetch(16'h50B0);
    step("st_decode", NONE);
    step("st_s0", PA(3'd2) | RDR | TP | LDY);
    step("st_s1", LMAR);
    step("st_s2", PA(3'd6) | RDR | TP | LDY);
    step("st_s3", RMDRI | LMDR);
    step("st_wait", MWR);
    mem_if.mem_ready = 1'b1;
    step("st_ready", MWR);
    check("ldst_flags", 32'(flags), 32'h1);

    // OR R7,R1,R2
    set_alu(4'b0111);
    fetch(16'h3E50);
    step("or_decode", NONE);
    step("or_ex0", PA(3'd1) | RDR | TP | LDX);
    step("or_ex1", PA(3'd2) | RDR | TP | LDY);
    set_alu(4'b1000);
    step("or_ex2", WRR | WPA(3'd7) | FN(3'b111));
    check("or_flags", 32'(flags), 32'h8);

    // JMP R3 ignores z
    fetch(16'h70C0);
    step("jmp_decode", NONE);
    step("jmp_b0", PA(3'd3) | RDR | TP | LDY);
    step("jmp_b1", LPC);

    // Unknown opcode 1010
    fetch(16'hA000);
    step("ill_decode", ILLEGAL);

    // HLT
    fetch(16'hF000);
    step("hlt_decode", NONE);
    for (int i = 0; i < 3; i++) begin
      mem_if.mem_ready = i[0];
      step("halt_hold", HALTED);
    end
    rst = 1'b0;
    #1;
    check("halt_rst_ctl", 32'(obs), 32'(NONE));
    check("halt_rst_flags", 32'(flags), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset landing mid-request drops mem_rd at once
    ir = 16'h0000;
    mem_if.mem_ready = 1'b0;
    step("mid_f0", TPC | LDY);
    step("mid_f1", LMAR | T2 | LDX);
    #2;
    check("mid_f2", 32'(obs), 32'(LPC | MRD | FN(3'b100)));
    rst = 1'b0;
    #1;
    check("mid_rst_drop", 32'(obs), 32'(NONE));
    @(posedge clk);
    #1;
    rst = 1'b1;

`ifdef CU_MEM_TIMEOUT_EN
    mem_if.mem_ready = 1'b0;
    step("to_f0", TPC | LDY);
    step("to_f1", LMAR | T2 | LDX);
    step("to_f2", LPC | MRD | FN(3'b100));
    check("to_clear", 32'(timeout), 32'h0);
    for (int i = 0; i < 16; i++) step("to_wait", MRD);
    step("to_halt", HALTED);
    check("to_sticky", 32'(timeout), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
